// File: rtl/lock_auto_operator.sv
// Automatic lockage sequencer for the canal lock: drives controlMain's gate and
// water commands from its status lights so one boat passes in either direction.
module lock_auto_operator #(
    parameter int TIMEOUT_CYC = 1000,
    parameter int SETTLE_CYC  = 4,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       auto_en,
    input  logic       dir,
    input  logic       arr_li,
    input  logic       occupied,
    input  logic       gate1_li,
    input  logic       gate2_li,
    input  logic       water_high,
    input  logic       water_low,
    input  logic       fault_clr,
    output logic       gate1_sw,
    output logic       gate2_sw,
    output logic       w_up,
    output logic       w_down,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        EQ_IN     = 4'd1,
        OPEN_IN   = 4'd2,
        WAIT_IN   = 4'd3,
        CLOSE_IN  = 4'd4,
        SETTLE    = 4'd5,
        EQ_OUT    = 4'd6,
        OPEN_OUT  = 4'd7,
        WAIT_OUT  = 4'd8,
        CLOSE_OUT = 4'd9,
        DONE      = 4'd10,
        FAULT     = 4'd15
    } state_t;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYC - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             dir_q, dir_n;
    logic             lvl_in, lvl_out;
    logic             timed, tmo;
    logic             g1_n, g2_n, up_n, dn_n;
    logic             busy_n, done_n, fault_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            dir_q    <= 1'b0;
            gate1_sw <= 1'b0;
            gate2_sw <= 1'b0;
            w_up     <= 1'b0;
            w_down   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            dir_q    <= dir_n;
            gate1_sw <= g1_n;
            gate2_sw <= g2_n;
            w_up     <= up_n;
            w_down   <= dn_n;
            busy     <= busy_n;
            done     <= done_n;
            fault    <= fault_n;
        end
    end

    assign state_o = state;

    always_comb begin
        state_n = state;
        // Direction is captured only on the IDLE exit; levels below use the
        // direction that will be in force next cycle so EQ_IN's first command is right.
        dir_n   = (state == IDLE && auto_en && arr_li) ? dir : dir_q;
        lvl_in  = dir_n ? water_low  : water_high;
        lvl_out = dir_n ? water_high : water_low;
        timed   = (state inside {EQ_IN, OPEN_IN, WAIT_IN, CLOSE_IN,
                                 EQ_OUT, OPEN_OUT, WAIT_OUT, CLOSE_OUT});
        tmo     = timed && (cnt == TMO_LAST);

        case (state)
            IDLE:      if (auto_en && arr_li)     state_n = EQ_IN;
            EQ_IN:     if (lvl_in)                state_n = OPEN_IN;
            OPEN_IN:   if (gate1_li)              state_n = WAIT_IN;
            WAIT_IN:   if (occupied && !arr_li)   state_n = CLOSE_IN;
            CLOSE_IN:  if (!gate1_li)             state_n = SETTLE;
            SETTLE:    if (cnt >= SET_LAST)       state_n = EQ_OUT;
            EQ_OUT:    if (lvl_out)               state_n = OPEN_OUT;
            OPEN_OUT:  if (gate2_li)              state_n = WAIT_OUT;
            WAIT_OUT:  if (!occupied)             state_n = CLOSE_OUT;
            CLOSE_OUT: if (!gate2_li)             state_n = DONE;
            DONE:                                 state_n = IDLE;
            FAULT:     if (fault_clr)             state_n = IDLE;
            default:                              state_n = IDLE;
        endcase

        // A handshake that stalls on its last allowed cycle lands in FAULT on the next edge.
        if (state_n == state && tmo)
            state_n = FAULT;

        if (state_n != state)
            cnt_n = '0;
        else if (timed || state == SETTLE)
            cnt_n = cnt + 1'b1;
        else
            cnt_n = cnt;

        g1_n = (state_n inside {OPEN_IN, WAIT_IN});
        g2_n = (state_n inside {OPEN_OUT, WAIT_OUT});
        up_n = (state_n == EQ_IN  && !dir_n && !lvl_in) ||
               (state_n == EQ_OUT &&  dir_n && !lvl_out);
        dn_n = (state_n == EQ_IN  &&  dir_n && !lvl_in) ||
               (state_n == EQ_OUT && !dir_n && !lvl_out);

        // Interlock: a water command always wins over any gate command.
        if (up_n || dn_n) begin
            g1_n = 1'b0;
            g2_n = 1'b0;
        end
        if (g1_n && g2_n)
            g2_n = 1'b0;
        if (up_n && dn_n) begin
            up_n = 1'b0;
            dn_n = 1'b0;
        end

        busy_n  = (state_n != IDLE);
        done_n  = (state_n == DONE);
        fault_n = (state_n == FAULT);
    end

endmodule
